// File: rtl/cpu_types_pkg.sv
// Shared type definitions for the CPU memory subsystem.
// Holds the RAM status encoding and the memory arbiter state/grant types.
package cpu_types_pkg;

    // RAM status as reported on ramstate
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        DREAD  = 2'd1,
        DWRITE = 2'd2
    } req_type_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req starting at ptr,
// wrapping modulo N. Reports whether anything was found and its index.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for NCORES cores (one I and one D miss port each).
// Optional macro ARB_TIMEOUT_EN adds a BUSY timeout abort and sticky arb_err.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ARB_IDLE    | no grant; scan write, then read, then fetch requests
// ARB_BUSY    | drive RAM from granted requester until ACCESS or withdrawal
// ARB_RELEASE | one idle cycle so the requester can move to its next address
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCORES  = 2,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NCORES-1:0]              iREN,
    input  logic [NCORES-1:0][WORD_W-1:0]  iaddr,
    output logic [NCORES-1:0]              iwait,
    output logic [NCORES-1:0][WORD_W-1:0]  iload,
    input  logic [NCORES-1:0]              dREN,
    input  logic [NCORES-1:0]              dWEN,
    input  logic [NCORES-1:0][WORD_W-1:0]  daddr,
    input  logic [NCORES-1:0][WORD_W-1:0]  dstore,
    output logic [NCORES-1:0]              dwait,
    output logic [NCORES-1:0][WORD_W-1:0]  dload,
    output logic                           ramREN,
    output logic                           ramWEN,
    output logic [WORD_W-1:0]              ramaddr,
    output logic [WORD_W-1:0]              ramstore,
    input  logic [WORD_W-1:0]              ramload,
    input  logic [1:0]                     ramstate
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                           arb_err
`endif
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    arb_state_t    state;
    req_type_t     gnt_type;
    logic [IW-1:0] gnt_core;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] next_ptr;

    logic          wr_vld, rd_vld, if_vld;
    logic [IW-1:0] wr_idx, rd_idx, if_idx;

    logic          req_live;
    logic          busy_live;
    logic          ram_access;
    logic          done;
    logic          to_abort;

    rr_picker #(.N(NCORES), .IW(IW)) u_pick_wr (
        .req   (dWEN),
        .ptr   (rr_ptr),
        .valid (wr_vld),
        .idx   (wr_idx)
    );

    rr_picker #(.N(NCORES), .IW(IW)) u_pick_rd (
        .req   (dREN),
        .ptr   (rr_ptr),
        .valid (rd_vld),
        .idx   (rd_idx)
    );

    rr_picker #(.N(NCORES), .IW(IW)) u_pick_if (
        .req   (iREN),
        .ptr   (rr_ptr),
        .valid (if_vld),
        .idx   (if_idx)
    );

    assign ram_access = (ramstate_t'(ramstate) == RAM_ACCESS);
    assign next_ptr   = (gnt_core == IW'(NCORES - 1)) ? '0 : gnt_core + 1'b1;

    // The granted request is tracked live; dropping it before ACCESS is a withdrawal.
    always_comb begin
        req_live = 1'b0;
        case (gnt_type)
            IFETCH:  req_live = iREN[gnt_core];
            DREAD:   req_live = dREN[gnt_core];
            DWRITE:  req_live = dWEN[gnt_core];
            default: req_live = 1'b0;
        endcase
    end

    assign busy_live = (state == ARB_BUSY) && req_live;
    assign done      = busy_live && ram_access;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (busy_live) begin
            ramREN  = (gnt_type != DWRITE);
            ramWEN  = (gnt_type == DWRITE);
            ramaddr = (gnt_type == IFETCH) ? iaddr[gnt_core] : daddr[gnt_core];
            if (gnt_type == DWRITE)
                ramstore = dstore[gnt_core];
        end
    end

    always_comb begin
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        if (done) begin
            if (gnt_type == IFETCH) begin
                iwait[gnt_core] = 1'b0;
                iload[gnt_core] = ramload;
            end else begin
                dwait[gnt_core] = 1'b0;
                dload[gnt_core] = ramload;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] to_cnt;

    assign to_abort = busy_live && !ram_access && (to_cnt == TW'(TIMEOUT - 1));

    // Counter sits at zero while idle so every BUSY entry starts from a clean count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt  <= '0;
            arb_err <= 1'b0;
        end else begin
            if (state == ARB_BUSY)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (to_abort)
                arb_err <= 1'b1;
        end
    end
`else
    assign to_abort = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ARB_IDLE;
            gnt_core <= '0;
            gnt_type <= IFETCH;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (wr_vld) begin
                        gnt_core <= wr_idx;
                        gnt_type <= DWRITE;
                        state    <= ARB_BUSY;
                    end else if (rd_vld) begin
                        gnt_core <= rd_idx;
                        gnt_type <= DREAD;
                        state    <= ARB_BUSY;
                    end else if (if_vld) begin
                        gnt_core <= if_idx;
                        gnt_type <= IFETCH;
                        state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!req_live) begin
                        state <= ARB_IDLE;
                    end else if (ram_access || to_abort) begin
                        rr_ptr <= next_ptr;
                        state  <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: state <= ARB_IDLE;
                default:     state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, class priority, round-robin, RAM latency,
// withdrawal, asynchronous reset and (with ARB_TIMEOUT_EN) the timeout abort.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int NC = 2;
    localparam int WW = 32;

    logic                    CLK;
    logic                    RST;
    logic [NC-1:0]           iREN;
    logic [NC-1:0][WW-1:0]   iaddr;
    logic [NC-1:0]           iwait;
    logic [NC-1:0][WW-1:0]   iload;
    logic [NC-1:0]           dREN;
    logic [NC-1:0]           dWEN;
    logic [NC-1:0][WW-1:0]   daddr;
    logic [NC-1:0][WW-1:0]   dstore;
    logic [NC-1:0]           dwait;
    logic [NC-1:0][WW-1:0]   dload;
    logic                    ramREN;
    logic                    ramWEN;
    logic [WW-1:0]           ramaddr;
    logic [WW-1:0]           ramstore;
    logic [WW-1:0]           ramload;
    logic [1:0]              ramstate;
`ifdef ARB_TIMEOUT_EN
    logic                    arb_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(.NCORES(NC), .WORD_W(WW), .TIMEOUT(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef ARB_TIMEOUT_EN
        ,
        .arb_err  (arb_err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        RST      = 1'b1;
        iREN     = '0;
        iaddr    = '0;
        dREN     = '0;
        dWEN     = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = 2'd0;
        #12;
        chk("rst_iwait",   32'(iwait),   32'h3);
        chk("rst_dwait",   32'(dwait),   32'h3);
        chk("rst_ramREN",  32'(ramREN),  32'h0);
        chk("rst_ramWEN",  32'(ramWEN),  32'h0);
        chk("rst_ramaddr", ramaddr,      32'h0);
        chk("rst_iload0",  iload[0],     32'h0);
        chk("rst_dload1",  dload[1],     32'h0);
`ifdef ARB_TIMEOUT_EN
        chk("rst_arb_err", 32'(arb_err), 32'h0);
`endif
        tick();
        RST = 1'b0;

        // Single fetch: core0, RAM answers immediately.
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h100;
        ramstate = 2'd2;
        ramload  = 32'hDEADBEEF;
        #1;
        chk("fetch_idle_ramREN", 32'(ramREN), 32'h0);
        chk("fetch_idle_iwait",  32'(iwait),  32'h3);
        tick();
        chk("fetch_ramREN",  32'(ramREN), 32'h1);
        chk("fetch_ramaddr", ramaddr,     32'h100);
        chk("fetch_iwait",   32'(iwait),  32'h2);
        chk("fetch_iload0",  iload[0],    32'hDEADBEEF);
        chk("fetch_iload1",  iload[1],    32'h0);
        tick();
        chk("fetch_rel_ramREN", 32'(ramREN), 32'h0);
        chk("fetch_rel_iwait",  32'(iwait),  32'h3);
        iREN[0] = 1'b0;
        tick();

        // Priority: core1 write (with read) and core0 fetch in the same cycle.
        iREN[0]   = 1'b1;
        iaddr[0]  = 32'h200;
        dREN[1]   = 1'b1;
        dWEN[1]   = 1'b1;
        daddr[1]  = 32'h300;
        dstore[1] = 32'h55;
        ramload   = 32'h1234;
        tick();
        chk("pri_wr_ramWEN",   32'(ramWEN), 32'h1);
        chk("pri_wr_ramREN",   32'(ramREN), 32'h0);
        chk("pri_wr_ramstore", ramstore,    32'h55);
        chk("pri_wr_ramaddr",  ramaddr,     32'h300);
        chk("pri_wr_dwait",    32'(dwait),  32'h1);
        chk("pri_wr_iwait",    32'(iwait),  32'h3);
        tick();
        chk("pri_rel_ramWEN", 32'(ramWEN), 32'h0);
        dWEN[1] = 1'b0;
        tick();
        chk("pri_idle_ramREN", 32'(ramREN), 32'h0);
        tick();
        chk("pri_rd_ramREN",  32'(ramREN), 32'h1);
        chk("pri_rd_ramaddr", ramaddr,     32'h300);
        chk("pri_rd_dwait",   32'(dwait),  32'h1);
        chk("pri_rd_dload1",  dload[1],    32'h1234);
        chk("pri_rd_iwait",   32'(iwait),  32'h3);
        tick();
        dREN[1] = 1'b0;
        tick();
        tick();
        chk("pri_if_ramaddr", ramaddr,     32'h200);
        chk("pri_if_iwait",   32'(iwait),  32'h2);
        chk("pri_if_iload0",  iload[0],    32'h1234);
        tick();
        iREN[0] = 1'b0;
        tick();

        // Round-robin from a fresh pointer: both cores hold dREN.
        RST = 1'b1;
        #1;
        RST = 1'b0;
        dREN     = 2'b11;
        daddr[0] = 32'hA0;
        daddr[1] = 32'hB0;
        ramload  = 32'hCAFE;
        for (int k = 0; k < 4; k++) begin
            chk("rr_idle_dwait", 32'(dwait), 32'h3);
            tick();
            chk("rr_busy_dwait",   32'(dwait), (k % 2 == 0) ? 32'h2 : 32'h1);
            chk("rr_busy_ramaddr", ramaddr,    (k % 2 == 0) ? 32'hA0 : 32'hB0);
            tick();
            chk("rr_rel_dwait", 32'(dwait), 32'h3);
            if (k == 3) dREN = '0;
            tick();
        end

        // RAM latency: five BUSY cycles before ACCESS on a core0 write.
        dWEN[0]   = 1'b1;
        daddr[0]  = 32'h40;
        dstore[0] = 32'h77;
        ramstate  = 2'd1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("lat_dwait",    32'(dwait),  32'h3);
            chk("lat_ramWEN",   32'(ramWEN), 32'h1);
            chk("lat_ramaddr",  ramaddr,     32'h40);
            chk("lat_ramstore", ramstore,    32'h77);
            tick();
        end
        ramstate = 2'd2;
        #1;
        chk("lat_done_dwait", 32'(dwait), 32'h2);
        tick();
        dWEN[0] = 1'b0;
        tick();

        // Withdrawal: core1 fetch dropped while RAM is busy.
        iREN[1]  = 1'b1;
        iaddr[1] = 32'h500;
        ramstate = 2'd1;
        tick();
        chk("wd_ramREN", 32'(ramREN), 32'h1);
        iREN[1] = 1'b0;
        #1;
        chk("wd_drop_ramREN", 32'(ramREN), 32'h0);
        chk("wd_drop_iwait",  32'(iwait),  32'h3);
        ramstate = 2'd2;
        tick();
        chk("wd_idle_ramREN", 32'(ramREN), 32'h0);
        chk("wd_idle_iwait",  32'(iwait),  32'h3);

        // Asynchronous reset in the middle of a BUSY read.
        dREN[0]  = 1'b1;
        daddr[0] = 32'h60;
        ramstate = 2'd1;
        tick();
        chk("rstb_ramREN", 32'(ramREN), 32'h1);
        RST = 1'b1;
        #1;
        chk("rstb_async_ramREN", 32'(ramREN), 32'h0);
        chk("rstb_async_dwait",  32'(dwait),  32'h3);
        tick();
        RST      = 1'b0;
        ramstate = 2'd2;
        #1;
        chk("rstb_idle_ramREN", 32'(ramREN), 32'h0);
        chk("rstb_idle_dwait",  32'(dwait),  32'h3);
        tick();
        chk("rstb_regrant_dwait", 32'(dwait), 32'h2);
        chk("rstb_regrant_addr",  ramaddr,    32'h60);
        tick();
        dREN[0] = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Timeout: RAM stuck BUSY; core1 is next by round-robin.
        dREN     = 2'b11;
        daddr[0] = 32'h60;
        daddr[1] = 32'h70;
        ramstate = 2'd1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("to_busy_dwait",   32'(dwait),   32'h3);
            chk("to_busy_ramaddr", ramaddr,      32'h70);
            chk("to_busy_err",     32'(arb_err), 32'h0);
            tick();
        end
        chk("to_rel_err",    32'(arb_err), 32'h1);
        chk("to_rel_ramREN", 32'(ramREN),  32'h0);
        chk("to_rel_dwait",  32'(dwait),   32'h3);
        tick();
        tick();
        chk("to_next_ramaddr", ramaddr, 32'h60);
        ramstate = 2'd2;
        #1;
        chk("to_next_dwait", 32'(dwait),   32'h2);
        chk("to_err_sticky", 32'(arb_err), 32'h1);
        tick();
        dREN = '0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared RAM port between the instruction and data cache miss requests of NCORES cores.
- Sits between the per-core icache/dcache miss interfaces and the RAM.
- Grants one request at a time through a small FSM.
- Class priority: data write, then data read, then instruction fetch. Round-robin across cores within each class.

Parameters:
- NCORES, 2, number of cores (each has one I port and one D port).
- WORD_W, 32, address and data width.
- TIMEOUT, 64, cycles allowed in BUSY before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  NCORES  instruction read request, per core.
- iaddr  in  NCORES x WORD_W  instruction address.
- iwait  out  NCORES  low for exactly the cycle iload is valid.
- iload  out  NCORES x WORD_W  instruction data.
- dREN  in  NCORES  data read request.
- dWEN  in  NCORES  data write request.
- daddr  in  NCORES x WORD_W  data address.
- dstore  in  NCORES x WORD_W  write data.
- dwait  out  NCORES  low for exactly the cycle a data access completes.
- dload  out  NCORES x WORD_W  data read result.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- arb_err  out  1  sticky timeout flag. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset values: state IDLE, rr_ptr 0, all iwait/dwait 1, ramREN/ramWEN 0, ramaddr/ramstore 0, iload/dload 0, arb_err 0.
- Reset asserted mid-transfer aborts immediately: RAM enables drop asynchronously and no wait is lowered.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - Scan requests by class: any dWEN, else any dREN, else any iREN.
  - Within a class, choose the first requesting core starting at rr_ptr, wrapping modulo NCORES.
  - dWEN and dREN both high on the same core is treated as a write.
  - If a request is found, register gnt_core and gnt_type (IFETCH/DREAD/DWRITE) and go to BUSY.
  - No RAM enables are driven in IDLE.
- BUSY:
  - ramaddr, ramstore and the enables come combinationally from the live signals of the granted requester. They are not latched; the requester holds them stable.
  - If ramstate==ACCESS:
    - lower the granted wait for this cycle only;
    - route ramload onto the granted iload/dload;
    - rr_ptr <= (gnt_core+1) mod NCORES;
    - go to RELEASE.
  - If the granted request deasserts before ACCESS: drop the enables the same cycle, no wait pulse, go to IDLE, rr_ptr unchanged.
  - ERROR or BUSY from the RAM: stay in BUSY and keep requesting.
- RELEASE:
  - One cycle with no RAM enables, so the requester can update its address.
  - Then go to IDLE.
- Minimum latency: request seen at cycle 0, grant registered at the end of cycle 0, wait low at cycle 1 if the RAM returns ACCESS immediately.
- Back-to-back throughput: one transfer per 3 cycles.
- Ungranted ports see wait=1 and load=0 at all times.
- Simultaneous I and D requests from the same core: D wins; I is served afterwards.
- Starvation bound: a pending instruction request is served once all data classes drain.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT-1 without ACCESS: abort to RELEASE with no wait pulse, set arb_err (sticky until RST), advance rr_ptr past gnt_core.
- ARB_TIMEOUT_EN undefined: no counter and no arb_err port; BUSY waits indefinitely.

Decomposition:
- Add to cpu_types_pkg:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR);
  - arb_state_t (IDLE, BUSY, RELEASE);
  - req_type_t (IFETCH, DREAD, DWRITE).
- One sub-module, rr_picker: combinational round-robin pick of a request vector given rr_ptr. Outputs a valid flag and an index. Instantiated once per class (three instances).

Test Plan:
- Single fetch: core0 iREN=1, iaddr=0x100, RAM returns ACCESS in 1 cycle with ramload=0xDEADBEEF -> iwait[0] low exactly at cycle 1, iload[0]=0xDEADBEEF, ramREN=0 during RELEASE.
- Priority: same cycle core0 iREN, core1 dREN, core1 dWEN with dstore=0x55 -> write served first (ramWEN=1, ramstore=0x55), then core1 read is served, then core0 fetch.
- Round-robin: both cores hold dREN continuously, RAM always ACCESS -> grants alternate 0,1,0,1; each dwait pulse is 1 cycle, 3 cycles apart.
- RAM latency: ramstate held BUSY for 5 cycles, then ACCESS -> dwait stays high 5 cycles, low on the 6th; enables held stable throughout.
- Withdrawal and reset: request dropped in BUSY -> enables fall the same cycle, no wait pulse. RST pulsed mid-BUSY -> all waits=1, enables=0 asynchronously, FSM in IDLE.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): ramstate stuck BUSY -> abort after 8 BUSY cycles, arb_err=1 and stays set, next core granted.
